// File: rtl/cro_scheduler.sv
// Two-requester round-robin front end for a single shared ConcatRepCondOp datapath.
// Optional grant statistics are enabled by defining CRO_SCHED_STATS_EN.

module ConcatRepCondOp (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       sel,
  output logic [7:0] concat_res,
  output logic [7:0] rep_res,
  output logic       cond_res
);

  assign concat_res = {in1, in2};
  assign rep_res    = {2{in1}};
  assign cond_res   = sel ? in1[0] : in2[0];

endmodule

module cro_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_in1,
  input  logic [3:0]  req0_in2,
  input  logic        req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_in1,
  input  logic [3:0]  req1_in2,
  input  logic        req1_sel,
`ifdef CRO_SCHED_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_concat,
  output logic [7:0]  rsp_rep,
  output logic        rsp_cond
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;

  logic [3:0]  op_in1_q, op_in1_d;
  logic [3:0]  op_in2_q, op_in2_d;
  logic        op_sel_q, op_sel_d;
  logic        op_id_q, op_id_d;

  logic        res_id_q, res_id_d;
  logic [7:0]  res_concat_q, res_concat_d;
  logic [7:0]  res_rep_q, res_rep_d;
  logic        res_cond_q, res_cond_d;

  logic        grant0_s, grant1_s;
  logic [7:0]  dp_concat_s, dp_rep_s;
  logic        dp_cond_s;

  ConcatRepCondOp u_dp (
    .in1        (op_in1_q),
    .in2        (op_in2_q),
    .sel        (op_sel_q),
    .concat_res (dp_concat_s),
    .rep_res    (dp_rep_s),
    .cond_res   (dp_cond_s)
  );

  // Arbitration: on contention the requester that did not win last time gets the grant.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_q;
      grant1_s = ~last_grant_q;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake readies only while idle, response valid only while holding a result.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0_s;
        req1_ready = grant1_s;
      end
      RESP:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Operand capture on the grant cycle and result capture out of the shared datapath.
  always_comb begin
    last_grant_d = last_grant_q;
    op_in1_d     = op_in1_q;
    op_in2_d     = op_in2_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    res_id_d     = res_id_q;
    res_concat_d = res_concat_q;
    res_rep_d    = res_rep_q;
    res_cond_d   = res_cond_q;
    if (req0_ready) begin
      op_in1_d     = req0_in1;
      op_in2_d     = req0_in2;
      op_sel_d     = req0_sel;
      op_id_d      = 1'b0;
      last_grant_d = 1'b0;
    end else if (req1_ready) begin
      op_in1_d     = req1_in1;
      op_in2_d     = req1_in2;
      op_sel_d     = req1_sel;
      op_id_d      = 1'b1;
      last_grant_d = 1'b1;
    end else begin
      op_id_d      = op_id_q;
    end
    if (state_q == EXEC) begin
      res_id_d     = op_id_q;
      res_concat_d = dp_concat_s;
      res_rep_d    = dp_rep_s;
      res_cond_d   = dp_cond_s;
    end else begin
      res_id_d     = res_id_q;
    end
  end

  // Datapath registers; reset discards any in-flight operand set and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      op_in1_q     <= 4'h0;
      op_in2_q     <= 4'h0;
      op_sel_q     <= 1'b0;
      op_id_q      <= 1'b0;
      res_id_q     <= 1'b0;
      res_concat_q <= 8'h00;
      res_rep_q    <= 8'h00;
      res_cond_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      op_in1_q     <= op_in1_d;
      op_in2_q     <= op_in2_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      res_id_q     <= res_id_d;
      res_concat_q <= res_concat_d;
      res_rep_q    <= res_rep_d;
      res_cond_q   <= res_cond_d;
    end
  end

  assign rsp_id     = res_id_q;
  assign rsp_concat = res_concat_q;
  assign rsp_rep    = res_rep_q;
  assign rsp_cond   = res_cond_q;

`ifdef CRO_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating per-requester grant counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != 16'hFFFF)) begin
      cnt0_d = cnt0_q + 16'd1;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (req1_ready && (cnt1_q != 16'hFFFF)) begin
      cnt1_d = cnt1_q + 16'd1;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_cro_scheduler.sv
// Directed bench for cro_scheduler: a cycle model predicts handshakes and a queue
// holds expected responses pushed at grant time and popped on the response handshake.

module tb_cro_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sel;
  logic [3:0] req0_in1, req0_in2;
  logic       req1_valid, req1_ready, req1_sel;
  logic [3:0] req1_in1, req1_in2;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cond;
  logic [7:0] rsp_concat, rsp_rep;
`ifdef CRO_SCHED_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  cro_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_sel   (req1_sel),
`ifdef CRO_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_concat (rsp_concat),
    .rsp_rep    (rsp_rep),
    .rsp_cond   (rsp_cond)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] concat;
    logic [7:0] rep;
    logic       cond;
  } rsp_t;

  rsp_t sb[$];
  rsp_t held;
  int   m_state;
  logic m_last;
  int   m_cnt0, m_cnt1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t expect_of(input logic id, input logic [3:0] a,
                                     input logic [3:0] b, input logic s);
    rsp_t r;
    r.id     = id;
    r.concat = {a, b};
    r.rep    = {a, a};
    r.cond   = s ? a[0] : b[0];
    return r;
  endfunction

  // One clock cycle: check outputs against the model, then advance model and clock.
  task automatic cycle();
    rsp_t obs;
    rsp_t front;
    logic e0, e1;
    #1;
    e0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
    e1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_state == 2)});
    obs = {rsp_id, rsp_concat, rsp_rep, rsp_cond};
    if (m_state == 2) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        front = sb[0];
        check("rsp_data", {14'd0, obs}, {14'd0, front});
        if (rsp_ready && !rst) begin
          void'(sb.pop_front());
          held = front;
        end
      end
    end else begin
      check("rsp_hold", {14'd0, obs}, {14'd0, held});
    end
`ifdef CRO_SCHED_STATS_EN
    check("grant_cnt0", {16'd0, grant_cnt0}, m_cnt0);
    check("grant_cnt1", {16'd0, grant_cnt1}, m_cnt1);
`endif
    if (rst) begin
      m_state = 0;
      m_last  = 1'b1;
      sb.delete();
      held    = '0;
      m_cnt0  = 0;
      m_cnt1  = 0;
    end else begin
      case (m_state)
        0: begin
          if (e0) begin
            sb.push_back(expect_of(1'b0, req0_in1, req0_in2, req0_sel));
            m_last = 1'b0;
            if (m_cnt0 < 65535) m_cnt0++;
            m_state = 1;
          end else if (e1) begin
            sb.push_back(expect_of(1'b1, req1_in1, req1_in2, req1_sel));
            m_last = 1'b1;
            if (m_cnt1 < 65535) m_cnt1++;
            m_state = 1;
          end
        end
        1: m_state = 2;
        2: if (rsp_ready) m_state = 0;
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_in1 = 4'h0; req0_in2 = 4'h0; req0_sel = 1'b0;
    req1_valid = 1'b0; req1_in1 = 4'h0; req1_in2 = 4'h0; req1_sel = 1'b0;
    rsp_ready = 1'b1;
    m_state = 0; m_last = 1'b1; held = '0; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single request with fixed expected literals at T+2.
    req0_valid = 1'b1; req0_in1 = 4'b1101; req0_in2 = 4'b1010; req0_sel = 1'b1;
    cycle();
    req0_valid = 1'b0;
    cycle();
    #1;
    check("single_valid",  {31'd0, rsp_valid},  32'd1);
    check("single_id",     {31'd0, rsp_id},     32'd0);
    check("single_concat", {24'd0, rsp_concat}, 32'b11011010);
    check("single_rep",    {24'd0, rsp_rep},    32'b11011101);
    check("single_cond",   {31'd0, rsp_cond},   32'd1);
    cycle();
    cycle();

    // Contention: both valid every cycle, grants alternate.
    req0_valid = 1'b1; req0_in1 = 4'b0110; req0_in2 = 4'b1001; req0_sel = 1'b0;
    req1_valid = 1'b1; req1_in1 = 4'b0101; req1_in2 = 4'b1100; req1_sel = 1'b1;
    repeat (12) cycle();

    // Backpressure with requests pending.
    rsp_ready = 1'b0;
    repeat (14) cycle();
    rsp_ready = 1'b1;
    repeat (4) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cycle();

    // Operand change after grant must not affect the in-flight result.
    req1_valid = 1'b1; req1_in1 = 4'b0001; req1_in2 = 4'b1110; req1_sel = 1'b0;
    cycle();
    req1_valid = 1'b0; req1_in1 = 4'b1111; req1_in2 = 4'b0000; req1_sel = 1'b1;
    cycle();
    #1;
    check("opchg_concat", {24'd0, rsp_concat}, 32'b00011110);
    check("opchg_cond",   {31'd0, rsp_cond},   32'd0);
    repeat (3) cycle();

    // Reset while in EXEC discards the transaction.
    req0_valid = 1'b1; req0_in1 = 4'b1010; req0_in2 = 4'b0101; req0_sel = 1'b1;
    cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
    check("rst_rsp_id",     {31'd0, rsp_id},     32'd0);
    check("rst_rsp_concat", {24'd0, rsp_concat}, 32'd0);
    check("rst_rsp_rep",    {24'd0, rsp_rep},    32'd0);
    check("rst_rsp_cond",   {31'd0, rsp_cond},   32'd0);
    repeat (3) cycle();

    // First contention after reset goes to requester 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_grant1", {31'd0, req1_ready}, 32'd0);
    repeat (14) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cycle();

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cro_scheduler.md
# cro_scheduler

Round-robin scheduler that shares one `ConcatRepCondOp` datapath instance between two requesters. Each requester submits an operand set `{in1, in2, sel}` over a valid/ready handshake. The scheduler grants one request at a time, registers the operands, and computes the result through the shared instance. It returns the concatenation, replication and conditional results, tagged with the requester ID, on a single valid/ready response port. It sits between the operand sources and any consumer of `ConcatRepCondOp` results.

## Interface
Parameters: none. Requester count fixed at 2 and operand width fixed at 4, matching `ConcatRepCondOp`.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand set
- req0_ready  output  1  requester 0 operand set accepted this cycle
- req0_in1 / req0_in2  input  4 each  requester 0 operands
- req0_sel  input  1  requester 0 selector
- req1_valid, req1_ready, req1_in1, req1_in2, req1_sel  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_concat  output  8  {in1, in2}
- rsp_rep  output  8  {2{in1}}
- rsp_cond  output  1  sel ? in1[0] : in2[0]

## Operation
- FSM states:
  - IDLE (reset state)
  - EXEC: operands registered, datapath evaluating
  - RESP: result held
- IDLE behaviour:
  - If any reqX_valid: grant one requester. Assert its reqX_ready combinationally in the same cycle. Capture its in1/in2/sel and ID into the operand register. Go to EXEC.
  - If no reqX_valid: stay in IDLE.
- EXEC: drive the registered operands into the shared `ConcatRepCondOp` instance. Capture concat_res/rep_res/cond_res and the ID into the result register. Go to RESP.
- RESP: rsp_valid=1 and all result outputs stable. On rsp_valid && rsp_ready, go to IDLE.
- Arbitration:
  - A 1-bit last_grant register resets to 1, so requester 0 wins the first contention.
  - Both valid: grant ~last_grant.
  - One valid: grant that one.
  - last_grant updates only on an actual grant.
- reqX_ready is 0 outside IDLE. At most one reqX_ready is high in any cycle.
- Operands are sampled only on the handshake cycle. Later changes on req inputs do not affect an in-flight result.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_concat=8'h00, rsp_rep=8'h00, rsp_cond=0. State returns to IDLE and last_grant to 1.
- Latency: handshake in cycle T gives rsp_valid=1 in cycle T+2.
- Peak throughput: one request per 3 cycles with rsp_ready tied high. The next grant can occur in the cycle after the response handshake.
- rsp_ready low holds RESP indefinitely. Outputs are stable and no requests are accepted.
- rst asserted in any state takes effect on the next edge. It overrides a simultaneous request or response handshake, and the in-flight transaction is discarded.
- rsp_* data is don't-care-free: it holds its last value when rsp_valid=0.

## Configuration
- `CRO_SCHED_STATS_EN` defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counts grants to its requester and saturates at 16'hFFFF.
  - Both clear to 0 on rst.
- Not defined: the counters and ports are absent, and behaviour is otherwise identical.

## Test plan
- Single request: req0 in1=1101, in2=1010, sel=1 at T -> rsp_valid at T+2, rsp_id=0, rsp_concat=11011010, rsp_rep=11011101, rsp_cond=1.
- Contention: both valid every cycle. req0 in1=0110, in2=1001, sel=0; req1 in1=0101, in2=1100, sel=1; rsp_ready=1 -> grants alternate 0,1,0,1. Responses: id0 concat=01101001, rep=01100110, cond=1. id1 concat=01011100, rep=01010101, cond=1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> outputs stable, req0_ready=req1_ready=0 throughout. Response completes on the first rsp_ready=1 cycle.
- Operand change after grant: req1 in1=0001, in2=1110, sel=0 accepted, then inputs changed to 1111/0000 -> response still concat=00011110, cond=0.
- Reset mid-op: assert rst in EXEC -> next cycle all outputs at reset values and no response emitted. First subsequent contention is granted to requester 0.
- With `CRO_SCHED_STATS_EN`: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2. rst -> both 0.
